// File: rtl/mem_pkg.sv
// Shared types, widths and address checking for the data-memory responder.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 8 * WORD_BYTES;
    localparam int unsigned BE_W       = WORD_BYTES;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields captured at the accept edge
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // Misaligned byte address or word index beyond the array
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth_words);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth_words));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage with per-byte write enables and a registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Byte-masked write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register doubles as the response data; zero unless a read landed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data-memory slave with programmable response latency.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    output logic        o_stall
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 4");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    mem_req_t          r_req;
    logic              r_rsp_error;

    logic              w_cnt_done;
    logic              w_err;
    logic              w_req_ready;
    logic              w_rsp_valid;
    logic              w_access;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_clr;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_cnt_done = (r_cnt == '0);
    assign w_err      = addr_err(r_req.addr, DEPTH_WORDS);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept, wait out the latency, hold the response until taken
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_req_valid) w_state_next = BUSY;
            BUSY:    if (w_cnt_done)  w_state_next = RESP;
            RESP:    if (i_rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs and memory strobes
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_access    = 1'b0;
        w_clr       = 1'b0;
        unique case (r_state)
            IDLE:    w_req_ready = 1'b1;
            BUSY:    w_access    = w_cnt_done;
            RESP: begin
                w_rsp_valid = 1'b1;
                w_clr       = i_rsp_ready;
            end
            default: w_req_ready = 1'b0;
        endcase
        w_wr_en = w_access & ~w_err &  r_req.write;
        w_rd_en = w_access & ~w_err & ~r_req.write;
    end

    // Request capture, latency counter and error flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req       <= '0;
            r_cnt       <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (r_state == IDLE && i_req_valid) begin
                r_req.write <= i_req_write;
                r_req.addr  <= i_req_addr;
                r_req.wdata <= i_req_wdata;
                r_req.be    <= i_req_be;
                r_cnt       <= CNT_W'(LATENCY - 1);
            end else if (r_state == BUSY && !w_cnt_done) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_access) begin
                r_rsp_error <= w_err;
            end else if (w_clr) begin
                r_rsp_error <= 1'b0;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr_en (w_wr_en),
        .i_rd_en (w_rd_en),
        .i_clr   (w_clr),
        .i_idx   (r_req.addr[IDX_W+1:2]),
        .i_wdata (r_req.wdata),
        .i_be    (r_req.be),
        .o_rdata (w_mem_rdata)
    );

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_rdata = w_mem_rdata;
    assign o_rsp_error = r_rsp_error;
    assign o_stall     = i_req_valid & ~w_req_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder with a cycle-level reference model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        stall;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_be    (req_be),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_error (rsp_error),
        .o_stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_idle = 1'b1;
    bit          m_resp = 1'b0;
    longint      cyc = 0;
    longint      m_due = 0;
    logic        m_w;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_be;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    always @(negedge rst_n) begin
        m_idle = 1'b1;
        m_resp = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_idle) begin
                if (req_valid) begin
                    m_w = req_write; m_a = req_addr; m_d = req_wdata; m_be = req_be;
                    m_idle = 1'b0;
                    m_due  = cyc + LAT;
                end
            end else if (!m_resp) begin
                if (cyc == m_due) begin
                    m_err   = (m_a % 4 != 0) || (m_a >= 4 * DEPTH);
                    m_rdata = 32'h0;
                    if (!m_err) begin
                        if (m_w) begin
                            for (int b = 0; b < 4; b++)
                                if (m_be[b]) m_mem[m_a / 4][8*b +: 8] = m_d[8*b +: 8];
                        end else begin
                            m_rdata = m_mem[m_a / 4];
                        end
                    end
                    m_resp = 1'b1;
                end
            end else if (rsp_ready) begin
                m_resp = 1'b0;
                m_idle = 1'b1;
            end
        end
        cyc++;
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, m_idle});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
        chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 32'h0);
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, m_resp & m_err});
        chk("stall",     {31'b0, stall},     {31'b0, req_valid & ~m_idle});
    end

    // ---------------- driver ----------------
    // Called at posedge+#1; returns at posedge+#1 after the response is taken.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int t;
        req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        rsp_ready = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no req_ready expected within 200 cycles");
                $fatal(1, "stuck");
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected after %0d edges", LAT);
        end
        rd = rsp_rdata;
        er = rsp_error;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;
        int          sel;

        // 1. reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
        @(posedge clk); #1;

        // zero the array so model and DUT start identical
        for (int i = 0; i < int'(DEPTH); i++) xact(1'b1, 32'(i * 4), 32'h0, 4'hF, 0, rd, er, lat);

        // 2. word write/read with latency
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("t2_wr_lat", 32'(lat), 32'd2);
        chk("t2_wr_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t2_rd_lat", 32'(lat), 32'd2);
        chk("t2_rd_rdata", rd, 32'hDEADBEEF);
        chk("t2_rd_err", {31'b0, er}, 32'h0);

        // 3. byte enables
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_be_merge", rd, 32'h11BB33DD);
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
        chk("t3_be0_err", {31'b0, er}, 32'h0);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_be0_keep", rd, 32'h11BB33DD);

        // 4. response held with a stalled requester
        req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1;
        repeat (LAT) begin @(posedge clk); #1; end
        rd = rsp_rdata;
        chk("t4_first", rd, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'b0, rsp_valid}, 32'h1);
            chk("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("t4_hold_ready", {31'b0, req_ready}, 32'h0);
            chk("t4_hold_stall", {31'b0, stall}, 32'h1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_back_idle", {31'b0, req_ready}, 32'h1);
        chk("t4_valid_low", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1;

        // 5. errors
        xact(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat);
        chk("t5_mis_err", {31'b0, er}, 32'h1);
        chk("t5_mis_rdata", rd, 32'h0);
        xact(1'b1, 32'h400, 32'h5A5A5A5A, 4'hF, 1, rd, er, lat);
        chk("t5_oor_err", {31'b0, er}, 32'h1);
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat);
        chk("t5_word0", rd, 32'h0);
        chk("t5_word0_err", {31'b0, er}, 32'h0);

        // 6. reset during BUSY aborts a write
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", {31'b0, req_ready}, 32'h1);
        chk("t6_rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("t6_rst_rdata", rsp_rdata, 32'h0);
        chk("t6_rst_error", {31'b0, rsp_error}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        xact(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
        chk("t6_no_write", rd, 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(DEPTH, 32'h0FFF_FFFF) * 4);
            else               a = $urandom;
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), rd, er, lat);
            chk("rnd_lat", 32'(lat), 32'(LAT));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
